// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between a CPU memory stage
// (master) and a data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and byte enables (bit i -> byte i)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : load data (0 for stores/errors) and error flag
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, performs
// the RAM access a fixed LATENCY after acceptance and returns a response that
// is held until the requester takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high (RAM contents are not reset)
//   bus  : request/response channels (slave side of dmem_responder_if)
//   busy : high whenever a request is in flight or a response is pending
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic       LAT_ONE  = (LATENCY == 1);
  // WAIT spends CNT_INIT+1 edges, so the access edge lands at accept+LATENCY-1.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        valid_r, valid_next_s;
  logic        ready_r, ready_next_s;
  logic        busy_r, busy_next_s;
  logic        accept_s, enter_resp_s, release_s;

  logic        lat_write_r;
  logic [31:0] lat_addr_r;
  logic [31:0] lat_wdata_r;
  logic [3:0]  lat_be_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        acc_write_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [3:0]  acc_be_s;
  logic [ADDR_W-1:0] acc_idx_s;
  logic        err_s;

  logic [31:0] mem_r [0:DEPTH-1];

  // Next-state, counter and registered-output decode for the IDLE/WAIT/RESP controller.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          if (LAT_ONE) begin
            state_next_s = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = CNT_INIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next_s = IDLE;
          release_s    = 1'b1;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
    valid_next_s = (state_next_s == RESP);
    ready_next_s = (state_next_s == IDLE);
    busy_next_s  = (state_next_s != IDLE);
  end

  // State, counter and handshake/busy output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      valid_r <= valid_next_s;
      ready_r <= ready_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // With LATENCY==1 the access happens on the accept edge itself, so the live
  // request fields are used in IDLE; otherwise the latched copy is used.
  always_comb begin
    if (state_r == IDLE) begin
      acc_write_s = bus.req_write;
      acc_addr_s  = bus.req_addr;
      acc_wdata_s = bus.req_wdata;
      acc_be_s    = bus.req_be;
    end else begin
      acc_write_s = lat_write_r;
      acc_addr_s  = lat_addr_r;
      acc_wdata_s = lat_wdata_r;
      acc_be_s    = lat_be_r;
    end
    acc_idx_s = acc_addr_s[ADDR_W+1:2];
    err_s     = (acc_addr_s[1:0] != 2'b00) | (|acc_addr_s[31:ADDR_W+2]);
  end

  // Request latch and response data/error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write_r <= 1'b0;
      lat_addr_r  <= 32'd0;
      lat_wdata_r <= 32'd0;
      lat_be_r    <= 4'd0;
      rdata_r     <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        lat_write_r <= bus.req_write;
        lat_addr_r  <= bus.req_addr;
        lat_wdata_r <= bus.req_wdata;
        lat_be_r    <= bus.req_be;
      end
      if (enter_resp_s) begin
        err_r   <= err_s;
        rdata_r <= (acc_write_s || err_s) ? 32'd0 : mem_r[acc_idx_s];
      end else if (release_s) begin
        err_r   <= 1'b0;
        rdata_r <= 32'd0;
      end
    end
  end

  // Byte-enabled RAM write on the access edge; suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp_s && acc_write_s && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be_s[b]) begin
          mem_r[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// load/store traffic against a word-array reference model; two extra
// instances with LATENCY=1 and LATENCY=15 check response timing and spacing.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_m, busy_1, busy_15;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [31:0] model_mem [0:1023];

  dmem_responder_if m_if();
  dmem_responder_if l1_if();
  dmem_responder_if l15_if();

  dmem_responder #(.ADDR_W(10), .LATENCY(2))  u_main (.clk(clk), .rst(rst), .bus(m_if.slave),   .busy(busy_m));
  dmem_responder #(.ADDR_W(10), .LATENCY(1))  u_l1   (.clk(clk), .rst(rst), .bus(l1_if.slave),  .busy(busy_1));
  dmem_responder #(.ADDR_W(10), .LATENCY(15)) u_l15  (.clk(clk), .rst(rst), .bus(l15_if.slave), .busy(busy_15));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour: error if misaligned or beyond 1024 words; stores merge bytes.
  function automatic void model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_err);
    int w;
    exp_err = (addr % 4 != 0) || (addr >= 32'd4096);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      w = int'(addr / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = model_mem[w];
      end
    end
  endfunction

  // One transaction on the main instance; rsp_ready held low for 'hold' cycles once rsp_valid appears.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, output logic [31:0] rdata, output logic err, output int lat,
                        output bit stable, output bit clean, output bit timeout);
    int n;
    timeout = 1'b0; stable = 1'b1; clean = 1'b1; lat = 0; rdata = 32'd0; err = 1'b0;
    @(negedge clk);
    m_if.req_write = wr; m_if.req_addr = addr; m_if.req_wdata = wdata; m_if.req_be = be;
    m_if.req_valid = 1'b1;
    m_if.rsp_ready = (hold == 0);
    n = 0;
    while (m_if.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (m_if.req_ready !== 1'b1) begin timeout = 1'b1; m_if.req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    m_if.req_valid = 1'b0;
    m_if.req_write = ~wr; m_if.req_addr = $urandom(); m_if.req_wdata = $urandom(); m_if.req_be = 4'($urandom());
    while (m_if.rsp_valid !== 1'b1 && lat < 40) begin
      if (m_if.req_ready !== 1'b0) stable = 1'b0;
      @(negedge clk); lat++;
    end
    if (m_if.rsp_valid !== 1'b1) begin timeout = 1'b1; m_if.rsp_ready = 1'b1; return; end
    rdata = m_if.rsp_rdata; err = m_if.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (m_if.rsp_valid !== 1'b1 || m_if.rsp_rdata !== rdata || m_if.rsp_err !== err ||
          m_if.req_ready !== 1'b0 || busy_m !== 1'b1) stable = 1'b0;
    end
    m_if.rsp_ready = 1'b1;
    @(negedge clk);
    if (m_if.rsp_valid !== 1'b0 || m_if.rsp_rdata !== 32'd0 || m_if.rsp_err !== 1'b0 ||
        m_if.req_ready !== 1'b1 || busy_m !== 1'b0) clean = 1'b0;
  endtask

  task automatic test_reset();
    compared++;
    if ({m_if.rsp_valid, m_if.req_ready, busy_m, m_if.rsp_err} !== 4'b0100) begin
      mismatched++; $display("FAIL reset_held: got %b expected 0100", {m_if.rsp_valid, m_if.req_ready, busy_m, m_if.rsp_err});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (m_if.req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready: got %b expected 1", m_if.req_ready); end
    compared++;
    if (m_if.rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid: got %b expected 0", m_if.rsp_valid); end
    compared++;
    if (m_if.rsp_rdata !== 32'd0) begin mismatched++; $display("FAIL reset_rdata: got %h expected 0", m_if.rsp_rdata); end
    compared++;
    if (busy_m !== 1'b0 || m_if.rsp_err !== 1'b0) begin mismatched++; $display("FAIL reset_busy_err: got %b%b expected 00", busy_m, m_if.rsp_err); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, cl, to;
    model_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || lat != 2) begin mismatched++; $display("FAIL store_latency: got %0d (timeout %0d) expected 2", lat, to); end
    compared++;
    if ({er, rd} !== 33'd0) begin mismatched++; $display("FAIL store_rsp: got err %b data %h expected err 0 data 0", er, rd); end
    model_txn(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || lat != 2) begin mismatched++; $display("FAIL load_latency: got %0d (timeout %0d) expected 2", lat, to); end
    compared++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin mismatched++; $display("FAIL load_data: got %h err %b expected deadbeef err 0", rd, er); end
    compared++;
    if (!cl) begin mismatched++; $display("FAIL load_release: got outputs not cleared expected idle/zero"); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, cl, to;
    model_txn(1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, cl, to);
    model_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, st, cl, to);
    model_txn(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || rd !== 32'h11BB33DD || er !== 1'b0) begin mismatched++; $display("FAIL byte_enable: got %h err %b expected 11bb33dd err 0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, cl, to;
    do_txn(1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || er !== 1'b1 || rd !== 32'd0) begin mismatched++; $display("FAIL misaligned_load: got err %b data %h expected err 1 data 0", er, rd); end
    do_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || er !== 1'b1 || rd !== 32'd0) begin mismatched++; $display("FAIL range_load: got err %b data %h expected err 1 data 0", er, rd); end
    compared++;
    if (!cl) begin mismatched++; $display("FAIL err_release: got err/data not cleared expected zero"); end
    do_txn(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || er !== 1'b1) begin mismatched++; $display("FAIL misaligned_store: got err %b expected 1", er); end
    model_txn(1'b1, 32'h20, 32'h55555555, 4'h0, erd, eer);
    do_txn(1'b1, 32'h20, 32'h55555555, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || er !== 1'b0) begin mismatched++; $display("FAIL be_zero_store: got err %b expected 0", er); end
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (rd !== 32'h11BB33DD) begin mismatched++; $display("FAIL err_no_write: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit st, cl, to;
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st, cl, to);
    compared++;
    if (to || rd !== 32'hDEADBEEF || er !== 1'b0) begin mismatched++; $display("FAIL bp_data: got %h err %b expected deadbeef err 0", rd, er); end
    compared++;
    if (!st) begin mismatched++; $display("FAIL bp_stable: got outputs changed while stalled expected stable"); end
    compared++;
    if (!cl) begin mismatched++; $display("FAIL bp_release: got outputs not cleared expected idle/zero"); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, cl, to; int n;
    model_txn(1'b1, 32'h40, 32'h12345678, 4'hF, erd, eer);
    do_txn(1'b1, 32'h40, 32'h12345678, 4'hF, 0, rd, er, lat, st, cl, to);
    @(negedge clk);
    m_if.req_write = 1'b1; m_if.req_addr = 32'h40; m_if.req_wdata = 32'hFFFFFFFF; m_if.req_be = 4'hF;
    m_if.req_valid = 1'b1;
    n = 0;
    while (m_if.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    m_if.req_valid = 1'b0;
    compared++;
    if (busy_m !== 1'b1 || m_if.rsp_valid !== 1'b0) begin mismatched++; $display("FAIL wait_state: got busy %b valid %b expected busy 1 valid 0", busy_m, m_if.rsp_valid); end
    #1 rst = 1'b1;
    #1;
    compared++;
    if ({m_if.rsp_valid, m_if.req_ready, busy_m, m_if.rsp_err, m_if.rsp_rdata} !== {4'b0100, 32'd0}) begin
      mismatched++; $display("FAIL async_reset: got v%b r%b b%b e%b d%h expected v0 r1 b0 e0 d0",
                             m_if.rsp_valid, m_if.req_ready, busy_m, m_if.rsp_err, m_if.rsp_rdata);
    end
    #1 rst = 1'b0;
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, st, cl, to);
    compared++;
    if (to || rd !== 32'h12345678) begin mismatched++; $display("FAIL dropped_store: got %h expected 12345678", rd); end
  endtask

  task automatic test_latency_builds();
    int last_acc[2]; bit prev_v[2]; int nacc[2]; int lat_exp[2];
    logic v, r;
    lat_exp[0] = 1; lat_exp[1] = 15;
    for (int k = 0; k < 2; k++) begin last_acc[k] = -1; prev_v[k] = 1'b0; nacc[k] = 0; end
    @(negedge clk);
    l1_if.req_write = 1'b0;  l1_if.req_addr = 32'h0;  l1_if.rsp_ready = 1'b1;  l1_if.req_valid = 1'b1;
    l15_if.req_write = 1'b0; l15_if.req_addr = 32'h0; l15_if.rsp_ready = 1'b1; l15_if.req_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      for (int k = 0; k < 2; k++) begin
        v = (k == 0) ? l1_if.rsp_valid : l15_if.rsp_valid;
        r = (k == 0) ? l1_if.req_ready : l15_if.req_ready;
        if (v === 1'b1 && !prev_v[k]) begin
          compared++;
          if (last_acc[k] < 0 || cyc - last_acc[k] + 1 != lat_exp[k]) begin
            mismatched++; $display("FAIL lat%0d_response: got %0d expected %0d", lat_exp[k], cyc - last_acc[k] + 1, lat_exp[k]);
          end
        end
        if (r === 1'b1) begin
          if (last_acc[k] >= 0) begin
            compared++;
            if (cyc + 1 - last_acc[k] != lat_exp[k] + 1) begin
              mismatched++; $display("FAIL lat%0d_spacing: got %0d expected %0d", lat_exp[k], cyc + 1 - last_acc[k], lat_exp[k] + 1);
            end
          end
          last_acc[k] = cyc + 1;
          nacc[k]++;
        end
        prev_v[k] = (v === 1'b1);
      end
      @(negedge clk);
    end
    l1_if.req_valid = 1'b0; l15_if.req_valid = 1'b0;
    compared++;
    if (nacc[0] < 30 || nacc[1] < 4) begin mismatched++; $display("FAIL lat_throughput: got %0d/%0d accepts expected >=30/>=4", nacc[0], nacc[1]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, wr; int lat; bit st, cl, to; logic [3:0] be; int sel;
    for (int w = 64; w < 80; w++) begin
      wd = $urandom();
      model_txn(1'b1, 32'(w * 4), wd, 4'hF, erd, eer);
      do_txn(1'b1, 32'(w * 4), wd, 4'hF, 0, rd, er, lat, st, cl, to);
    end
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      addr = 32'($urandom_range(64, 79) * 4);
      if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = 32'h1000 + (32'($urandom()) & 32'h0FFF_FFFC);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      be = 4'($urandom());
      model_txn(wr, addr, wd, be, erd, eer);
      do_txn(wr, addr, wd, be, $urandom_range(0, 2), rd, er, lat, st, cl, to);
      compared++;
      if (to || rd !== erd || er !== eer || lat != 2 || !st || !cl) begin
        mismatched++;
        $display("FAIL random_%0d: got data %h err %b lat %0d stable %0d clean %0d expected data %h err %b lat 2 stable 1 clean 1 (wr %b addr %h be %b)",
                 t, rd, er, lat, st, cl, erd, eer, wr, addr, be);
      end
    end
  endtask

  initial begin
    m_if.req_valid = 1'b0; m_if.req_write = 1'b0; m_if.req_addr = 32'd0; m_if.req_wdata = 32'd0; m_if.req_be = 4'd0; m_if.rsp_ready = 1'b0;
    l1_if.req_valid = 1'b0; l1_if.req_write = 1'b0; l1_if.req_addr = 32'd0; l1_if.req_wdata = 32'd0; l1_if.req_be = 4'd0; l1_if.rsp_ready = 1'b1;
    l15_if.req_valid = 1'b0; l15_if.req_write = 1'b0; l15_if.req_addr = 32'd0; l15_if.req_wdata = 32'd0; l15_if.req_be = 4'd0; l15_if.rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_latency_builds();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
